// File: rtl/sync_tracker.sv
// Receive-side SVGA sync tracker: measures incoming hsync/vsync timing, regenerates
// position counters aligned to the sync leading edges and reports lock / loss of signal.
module sync_tracker #(
   parameter int CNT_W       = 16,
   parameter int LOCK_FRAMES = 2,
   parameter int H_TOL       = 1,
   parameter int TIMEOUT     = 4096
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             hsync_in,
   input  logic             vsync_in,
   output logic [CNT_W-1:0] hpos,
   output logic [CNT_W-1:0] vpos,
   output logic [CNT_W-1:0] line_period,
   output logic [CNT_W-1:0] hsync_width,
   output logic [CNT_W-1:0] frame_lines,
   output logic [CNT_W-1:0] vsync_lines,
   output logic             new_line,
   output logic             new_frame,
   output logic             locked,
   output logic             no_signal
);
   // state   | meaning
   // NOSIG   | no hsync edge seen within TIMEOUT clocks
   // ACQUIRE | edges present, counting consecutive matching frames
   // LOCKED  | LOCK_FRAMES matching frames seen, timing stable
   typedef enum logic [1:0] {NOSIG, ACQUIRE, LOCKED} state_t;

   state_t           state_q;
   logic [3:0]       match_cnt_q;
   logic             first_q, locked_q, no_signal_q;

   logic             h_s1_q, h_s2_q, h_d_q, v_s1_q, v_s2_q, v_d_q;
   logic             h_rise, h_fall, v_rise, v_fall;

   logic [CNT_W-1:0] hpos_q, hpos_d, vpos_q, vpos_d;
   logic [CNT_W-1:0] line_period_q, line_period_d, hsync_width_q, hsync_width_d;
   logic [CNT_W-1:0] frame_lines_q, frame_lines_d, vsync_lines_q, vsync_lines_d;
   logic [CNT_W-1:0] vs_cnt_q, vs_cnt_d;
   logic             new_line_q, new_line_d, new_frame_q, new_frame_d;
   logic             mm_flag_q, mm_flag_d;

   logic [CNT_W-1:0] period_new, period_diff;
   logic             line_mm, frame_match, timeout;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a);
      return (&a) ? a : a + CNT_W'(1);
   endfunction

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         h_s1_q <= 1'b0;
         h_s2_q <= 1'b0;
         h_d_q  <= 1'b0;
         v_s1_q <= 1'b0;
         v_s2_q <= 1'b0;
         v_d_q  <= 1'b0;
      end else begin
         h_s1_q <= hsync_in;
         h_s2_q <= h_s1_q;
         h_d_q  <= h_s2_q;
         v_s1_q <= vsync_in;
         v_s2_q <= v_s1_q;
         v_d_q  <= v_s2_q;
      end
   end

   assign h_rise = h_s2_q & ~h_d_q;
   assign h_fall = ~h_s2_q & h_d_q;
   assign v_rise = v_s2_q & ~v_d_q;
   assign v_fall = ~v_s2_q & v_d_q;

   always_comb begin
      period_new    = sat_inc(hpos_q);
      period_diff   = (period_new > line_period_q) ? period_new - line_period_q
                                                   : line_period_q - period_new;
      line_mm       = h_rise && (period_diff > CNT_W'(H_TOL));

      hpos_d        = h_rise ? '0 : sat_inc(hpos_q);
      line_period_d = h_rise ? period_new : line_period_q;
      hsync_width_d = h_fall ? sat_inc(hpos_q) : hsync_width_q;

      vpos_d = vpos_q;
      if (v_rise)      vpos_d = '0;
      else if (h_rise) vpos_d = sat_inc(vpos_q);

      // a line whose hsync edge coincides with the vsync edge belongs to the closing frame
      frame_lines_d = frame_lines_q;
      if (v_rise) frame_lines_d = h_rise ? sat_inc(vpos_q) : vpos_q;

      vs_cnt_d = vs_cnt_q;
      if (v_rise)                vs_cnt_d = '0;
      else if (h_rise && v_s2_q) vs_cnt_d = sat_inc(vs_cnt_q);

      vsync_lines_d = vsync_lines_q;
      if (v_fall) vsync_lines_d = h_rise ? sat_inc(vs_cnt_q) : vs_cnt_q;

      mm_flag_d   = v_rise ? 1'b0 : (mm_flag_q | line_mm);
      new_line_d  = h_rise;
      new_frame_d = v_rise;

      frame_match = v_rise && !first_q && (frame_lines_d == frame_lines_q)
                    && !(mm_flag_q || line_mm);
      timeout     = !h_rise && (hpos_q >= CNT_W'(TIMEOUT - 1));
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         hpos_q        <= '0;
         vpos_q        <= '0;
         line_period_q <= '0;
         hsync_width_q <= '0;
         frame_lines_q <= '0;
         vsync_lines_q <= '0;
         vs_cnt_q      <= '0;
         new_line_q    <= 1'b0;
         new_frame_q   <= 1'b0;
         mm_flag_q     <= 1'b0;
      end else begin
         hpos_q        <= hpos_d;
         vpos_q        <= vpos_d;
         line_period_q <= line_period_d;
         hsync_width_q <= hsync_width_d;
         frame_lines_q <= frame_lines_d;
         vsync_lines_q <= vsync_lines_d;
         vs_cnt_q      <= vs_cnt_d;
         new_line_q    <= new_line_d;
         new_frame_q   <= new_frame_d;
         mm_flag_q     <= mm_flag_d;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q     <= NOSIG;
         match_cnt_q <= '0;
         first_q     <= 1'b0;
         locked_q    <= 1'b0;
         no_signal_q <= 1'b1;
      end else if (timeout) begin
         state_q     <= NOSIG;
         match_cnt_q <= '0;
         locked_q    <= 1'b0;
         no_signal_q <= 1'b1;
      end else begin
         case (state_q)
            NOSIG: begin
               if (h_rise) begin
                  state_q     <= ACQUIRE;
                  no_signal_q <= 1'b0;
                  first_q     <= 1'b1;
                  match_cnt_q <= '0;
               end
            end
            ACQUIRE: begin
               if (v_rise) begin
                  first_q <= 1'b0;
                  if (!frame_match) begin
                     match_cnt_q <= '0;
                  end else if (match_cnt_q + 4'd1 == 4'(LOCK_FRAMES)) begin
                     match_cnt_q <= match_cnt_q + 4'd1;
                     state_q     <= LOCKED;
                     locked_q    <= 1'b1;
                  end else begin
                     match_cnt_q <= match_cnt_q + 4'd1;
                  end
               end
            end
            LOCKED: begin
               if (line_mm || (v_rise && !frame_match)) begin
                  state_q     <= ACQUIRE;
                  match_cnt_q <= '0;
                  locked_q    <= 1'b0;
               end
            end
            default: state_q <= NOSIG;
         endcase
      end
   end

   assign hpos        = hpos_q;
   assign vpos        = vpos_q;
   assign line_period = line_period_q;
   assign hsync_width = hsync_width_q;
   assign frame_lines = frame_lines_q;
   assign vsync_lines = vsync_lines_q;
   assign new_line    = new_line_q;
   assign new_frame   = new_frame_q;
   assign locked      = locked_q;
   assign no_signal   = no_signal_q;
endmodule

// File: doc/sync_tracker.md
Name: sync_tracker

Overview:
- Receive end of the SVGA sync interface. Consumes hsync/vsync as produced by our sync generator (active-high pulses; 800x600, 40 MHz dot clock) or by an external video source.
- Measures line period, hsync width, lines per frame and vsync width.
- Regenerates horizontal/vertical position counters aligned to the sync leading edges.
- Declares lock once timing repeats for LOCK_FRAMES consecutive frames.
- Feeds capture/overlay logic and the timing-status registers.

Parameters:
- CNT_W, 16, width of all counters and measurement outputs.
- LOCK_FRAMES, 2, consecutive matching frames required to assert locked (1..15).
- H_TOL, 1, allowed line-period deviation in clocks before a line is considered mismatched.
- TIMEOUT, 4096, clocks without an hsync rising edge before declaring no signal.

Ports:
- clk  in  1  dot clock
- nrst  in  1  asynchronous active-low reset
- hsync_in  in  1  horizontal sync, asynchronous to clk, active high
- vsync_in  in  1  vertical sync, asynchronous to clk, active high
- hpos  out  CNT_W  clocks since last hsync rising edge (0 = edge cycle)
- vpos  out  CNT_W  hsync rising edges since last vsync rising edge
- line_period  out  CNT_W  last measured clocks between hsync rising edges
- hsync_width  out  CNT_W  last measured hsync high time in clocks
- frame_lines  out  CNT_W  last measured lines between vsync rising edges
- vsync_lines  out  CNT_W  hsync rising edges counted while vsync high, last frame
- new_line  out  1  one-clock pulse on each registered hsync rising edge
- new_frame  out  1  one-clock pulse on each registered vsync rising edge
- locked  out  1  timing stable
- no_signal  out  1  no hsync activity within TIMEOUT

Behaviour:
- Reset (async, nrst=0):
  - All counters and measurement outputs = 0.
  - new_line = new_frame = locked = 0; no_signal = 1; state = NOSIG.
  - Synchroniser flops clear to 0.
  - Reset mid-operation discards all measurements and lock.
- Input path:
  - Each sync input goes through a 2-flop synchroniser plus a delay flop.
  - rise = s & ~d; fall = ~s & d.
  - A registered effect occurs on the 3rd rising clk edge after the input transition.
- Horizontal, on an h rise:
  - hpos <= 0; line_period <= hpos+1; new_line <= 1.
  - Otherwise hpos increments, saturating at all-ones.
- On an h fall: hsync_width <= hpos+1.
- Vertical:
  - vpos increments on each h rise.
  - On a v rise: frame_lines <= vpos (+1 if an h rise occurs the same cycle); vpos <= 0; new_frame <= 1.
  - The vsync-high line counter clears on a v rise and increments on h rises while synchronised vsync is high.
  - On a v fall: vsync_lines <= that counter (+1 if an h rise occurs the same cycle).
- Line mismatch: a new line_period differing from the previous one by more than H_TOL sets a per-frame mismatch flag. The flag clears at each v rise after evaluation.
- State machine:
  - NOSIG: no_signal=1, locked=0. First h rise -> ACQUIRE; clear no_signal.
  - ACQUIRE: at each v rise, a frame matches if frame_lines equals the previous frame_lines and the mismatch flag is clear. On a match, match_cnt++; otherwise match_cnt <= 0. When match_cnt reaches LOCK_FRAMES -> LOCKED, and locked <= 1 in the same cycle.
  - The first v rise after entering ACQUIRE never counts as a match (no previous frame).
  - LOCKED: any mismatched frame, or any line mismatch, -> ACQUIRE with locked <= 0 and match_cnt <= 0 on that cycle.
  - Any state: hpos reaching TIMEOUT-1 with no h rise -> NOSIG; no_signal <= 1, locked <= 0; hpos/vpos hold, saturated.
- Measurements always update regardless of state. Consumers qualify them with locked.
- Widths: all arithmetic is CNT_W unsigned. +1 operations saturate rather than wrap.

Test Plan:
- Drive the sync generator output (H total 1056, hsync 128 clk; V total 628, vsync 4 lines) -> line_period=1056, hsync_width=128, frame_lines=628, vsync_lines=4. locked rises at the 3rd v rise after the first h rise; new_frame pulses once per frame.
- Latency check: hsync_in rises between edges -> new_line high during the cycle after the 3rd rising edge; hpos=0 that cycle, 1 the next.
- Once locked, stretch one line to 1060 clocks -> locked drops at the next h rise. Re-lock after 1 discarded frame plus LOCK_FRAMES matching frames.
- Hold hsync_in low after lock -> no_signal=1 and locked=0 exactly TIMEOUT clocks after the last registered h rise. Resume -> no_signal clears on the first h rise.
- Assert nrst mid-frame while locked -> all outputs 0 immediately (asynchronous), no_signal=1. After release, relock requires full acquisition.
- v rise in the same cycle as an h rise -> frame_lines includes that line (628, not 627), vpos=0.
